// File: rtl/uart_cmd_ctrl_pkg.sv
// uart_cmd_ctrl_pkg
//   Shared definitions for the UART debug command sequencer and the debug
//   core it feeds: FSM state encoding, frame marker default, opcode values
//   carried in the OP byte, and the error codes the sequencer reports.
package uart_cmd_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_HUNT    = 3'd0,
    ST_OP      = 3'd1,
    ST_LEN     = 3'd2,
    ST_PAYLOAD = 3'd3,
    ST_CSUM    = 3'd4,
    ST_ISSUE   = 3'd5
  } state_t;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;

  // Opcodes understood by the debug/programming engine.
  localparam logic [7:0] OPC_NOP       = 8'h00;
  localparam logic [7:0] OPC_READ_MEM  = 8'h10;
  localparam logic [7:0] OPC_WRITE_MEM = 8'h11;
  localparam logic [7:0] OPC_READ_REG  = 8'h20;
  localparam logic [7:0] OPC_WRITE_REG = 8'h21;
  localparam logic [7:0] OPC_HALT      = 8'h30;
  localparam logic [7:0] OPC_RUN       = 8'h31;
  localparam logic [7:0] OPC_STEP      = 8'h32;
  localparam logic [7:0] OPC_PROG      = 8'h40;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'd0,
    ERR_CSUM    = 2'd1,
    ERR_LEN     = 2'd2,
    ERR_TIMEOUT = 2'd3
  } err_t;

  // 8-bit wrap-around checksum accumulate.
  function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
    return acc + b;
  endfunction

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if
//   Bundles the receiver byte handshake, the command valid/ready channel,
//   the payload read port and the error pulses. Names are from the
//   sequencer's point of view (i_ = into the sequencer, o_ = out of it).
//   slave  : the sequencer side
//   master : the environment side (UART receiver + debug core)
interface uart_cmd_ctrl_if #(
  parameter int MAX_LEN = 16
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);

  logic [7:0]    i_rx_data;
  logic          i_rx_rdy;
  logic          o_rx_ack;
  logic          o_cmd_valid;
  logic          i_cmd_ready;
  logic [7:0]    o_cmd_op;
  logic [LW-1:0] o_cmd_len;
  logic [AW-1:0] i_pl_addr;
  logic [7:0]    o_pl_data;
  logic          o_err_csum;
  logic          o_err_len;
  logic          o_err_timeout;

  modport slave (
    input  i_rx_data, i_rx_rdy, i_cmd_ready, i_pl_addr,
    output o_rx_ack, o_cmd_valid, o_cmd_op, o_cmd_len, o_pl_data,
           o_err_csum, o_err_len, o_err_timeout
  );

  modport master (
    output i_rx_data, i_rx_rdy, i_cmd_ready, i_pl_addr,
    input  o_rx_ack, o_cmd_valid, o_cmd_op, o_cmd_len, o_pl_data,
           o_err_csum, o_err_len, o_err_timeout
  );
endinterface

// File: rtl/uart_cmd_ctrl_cmd_payload_buf.sv
// cmd_payload_buf
//   DEPTH x 8 register file holding the payload of the frame being
//   assembled. One synchronous write port, one combinational read port.
//   Contents are deliberately not reset.
//   i_clk            clock
//   i_we/i_waddr/i_wdata  write port
//   i_raddr/o_rdata       combinational read port
module cmd_payload_buf #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          i_clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [7:0]    i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [7:0]    o_rdata
);
  logic [DEPTH-1:0][7:0] r_mem;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl
//   Drains the UART receiver byte stream and assembles framed debug
//   commands: SYNC, OP, LEN, PAYLOAD[LEN], CSUM. A frame whose 8-bit sum
//   over OP..CSUM is zero is held on the command channel until the debug
//   core takes it; during that time no bytes are acked, so the receiver
//   holds off. Oversize LEN, bad checksum and inter-byte stalls abandon
//   the frame with a one-cycle error pulse.
//   i_clk, i_rst_n  clock, async active-low reset
//   bus (slave)     rx handshake, command channel, payload read, errors
module uart_cmd_ctrl
  import uart_cmd_ctrl_pkg::*;
#(
  parameter int         MAX_LEN        = 16,
  parameter int         TIMEOUT_CYCLES = 21700,
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  uart_cmd_ctrl_if.slave   bus
);
  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int AW = $clog2(MAX_LEN);
  localparam int TW = $clog2(TIMEOUT_CYCLES);

  state_t        r_state, w_state_nxt;
  logic [7:0]    r_op, w_op_nxt;
  logic [7:0]    r_csum, w_csum_nxt;
  logic [LW-1:0] r_len, w_len_nxt;
  logic [LW-1:0] r_idx, w_idx_nxt;
  logic [TW-1:0] r_tmo, w_tmo_nxt;
  err_t          r_err, w_err_nxt;

  logic w_ack, w_consume, w_counting, w_tmo_hit, w_wr_en;
  logic [7:0] w_csum_sum;

  // Ack is held low during reset even though the state already reads HUNT.
  assign w_ack      = i_rst_n && bus.i_rx_rdy && (r_state != ST_ISSUE);
  assign w_consume  = w_ack;
  assign w_counting = (r_state == ST_OP) || (r_state == ST_LEN) ||
                      (r_state == ST_PAYLOAD) || (r_state == ST_CSUM);
  // A consume on the terminal count cycle keeps the frame alive.
  assign w_tmo_hit  = w_counting && !w_consume &&
                      (r_tmo == TW'(TIMEOUT_CYCLES - 1));
  assign w_csum_sum = csum_add(r_csum, bus.i_rx_data);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_HUNT;
      r_op    <= '0;
      r_csum  <= '0;
      r_len   <= '0;
      r_idx   <= '0;
      r_tmo   <= '0;
      r_err   <= ERR_NONE;
    end else begin
      r_state <= w_state_nxt;
      r_op    <= w_op_nxt;
      r_csum  <= w_csum_nxt;
      r_len   <= w_len_nxt;
      r_idx   <= w_idx_nxt;
      r_tmo   <= w_tmo_nxt;
      r_err   <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_op_nxt    = r_op;
    w_csum_nxt  = r_csum;
    w_len_nxt   = r_len;
    w_idx_nxt   = r_idx;
    w_err_nxt   = ERR_NONE;
    w_wr_en     = 1'b0;
    w_tmo_nxt   = (w_counting && !w_consume) ? r_tmo + TW'(1) : '0;

    case (r_state)
      ST_HUNT: begin
        if (w_consume && bus.i_rx_data == SYNC_BYTE) w_state_nxt = ST_OP;
      end
      ST_OP: begin
        if (w_consume) begin
          w_op_nxt    = bus.i_rx_data;
          w_csum_nxt  = bus.i_rx_data;
          w_state_nxt = ST_LEN;
        end
      end
      ST_LEN: begin
        if (w_consume) begin
          if (bus.i_rx_data > 8'(MAX_LEN)) begin
            w_err_nxt   = ERR_LEN;
            w_state_nxt = ST_HUNT;
          end else begin
            w_len_nxt   = LW'(bus.i_rx_data);
            w_csum_nxt  = w_csum_sum;
            w_idx_nxt   = '0;
            w_state_nxt = (bus.i_rx_data == 8'd0) ? ST_CSUM : ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (w_consume) begin
          w_wr_en    = 1'b1;
          w_csum_nxt = w_csum_sum;
          w_idx_nxt  = r_idx + LW'(1);
          if (r_idx == r_len - LW'(1)) w_state_nxt = ST_CSUM;
        end
      end
      ST_CSUM: begin
        if (w_consume) begin
          if (w_csum_sum == 8'd0) begin
            w_state_nxt = ST_ISSUE;
          end else begin
            w_err_nxt   = ERR_CSUM;
            w_state_nxt = ST_HUNT;
          end
        end
      end
      ST_ISSUE: begin
        if (bus.i_cmd_ready) w_state_nxt = ST_HUNT;
      end
      default: w_state_nxt = ST_HUNT;
    endcase

    if (w_tmo_hit) begin
      w_state_nxt = ST_HUNT;
      w_err_nxt   = ERR_TIMEOUT;
      w_tmo_nxt   = '0;
    end
  end

  cmd_payload_buf #(.DEPTH(MAX_LEN), .AW(AW)) u_buf (
    .i_clk   (i_clk),
    .i_we    (w_wr_en),
    .i_waddr (r_idx[AW-1:0]),
    .i_wdata (bus.i_rx_data),
    .i_raddr (bus.i_pl_addr),
    .o_rdata (bus.o_pl_data)
  );

  assign bus.o_rx_ack      = w_ack;
  assign bus.o_cmd_valid   = (r_state == ST_ISSUE);
  assign bus.o_cmd_op      = r_op;
  assign bus.o_cmd_len     = r_len;
  assign bus.o_err_csum    = (r_err == ERR_CSUM);
  assign bus.o_err_len     = (r_err == ERR_LEN);
  assign bus.o_err_timeout = (r_err == ERR_TIMEOUT);
endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl
//   Directed frame table plus hand sequences for backpressure, timeout,
//   max length and asynchronous reset.
module tb_uart_cmd_ctrl;
  localparam int MAX_LEN = 16;
  localparam int TMO     = 21700;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  uart_cmd_ctrl_if #(.MAX_LEN(MAX_LEN)) bus ();

  uart_cmd_ctrl #(.MAX_LEN(MAX_LEN), .TIMEOUT_CYCLES(TMO), .SYNC_BYTE(8'hA5)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus.slave)
  );

  typedef struct {
    string           name;
    int              n;
    logic [0:7][7:0] b;
    logic            exp_valid;
    logic [7:0]      exp_op;
    int              exp_len;
    logic [7:0]      exp_pl0;
    logic [7:0]      exp_pl1;
    logic            exp_ecsum;
    logic            exp_elen;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input int n, input logic [63:0] b,
                     input logic v, input logic [7:0] op, input int len,
                     input logic [7:0] p0, input logic [7:0] p1,
                     input logic ec, input logic el);
    vec_t t;
    t.name = name; t.n = n; t.b = b; t.exp_valid = v; t.exp_op = op;
    t.exp_len = len; t.exp_pl0 = p0; t.exp_pl1 = p1;
    t.exp_ecsum = ec; t.exp_elen = el;
    vecs.push_back(t);
  endtask

  // Called near a falling edge; returns at the falling edge after the consume.
  task automatic send_byte(input logic [7:0] d);
    int waited = 0;
    bus.i_rx_data = d;
    bus.i_rx_rdy  = 1'b1;
    #1;
    while (bus.o_rx_ack !== 1'b1) begin
      @(negedge clk);
      #1;
      waited++;
      if (waited > 100) break;
    end
    if (waited > 100) begin
      n_chk++; n_fail++;
      $display("FAIL ack_wait: byte %0h not acked within 100 cycles", d);
      bus.i_rx_rdy = 1'b0;
    end else begin
      @(negedge clk);
      bus.i_rx_rdy = 1'b0;
    end
  endtask

  task automatic drain(input string name);
    bus.i_cmd_ready = 1'b1;
    @(negedge clk);
    bus.i_cmd_ready = 1'b0;
    #1 chk({name, "_valid_drop"}, 32'(bus.o_cmd_valid), 32'd0);
  endtask

  initial begin
    int bad, first, cnt;
    bus.i_rx_data = 8'h00; bus.i_rx_rdy = 1'b0; bus.i_cmd_ready = 1'b0;
    bus.i_pl_addr = '0;

    add("good",     6, 64'hA5100211_22BB0000, 1, 8'h10, 2, 8'h11, 8'h22, 0, 0);
    add("badcsum",  6, 64'hA5100211_22BC0000, 0, 8'h00, 0, 8'h00, 8'h00, 1, 0);
    add("good3",    7, 64'hA5210301_0203D600, 1, 8'h21, 3, 8'h01, 8'h02, 0, 0);
    add("oversize", 3, 64'hA5201100_00000000, 0, 8'h00, 0, 8'h00, 8'h00, 0, 1);
    add("zerolen",  4, 64'hA53000D0_00000000, 1, 8'h30, 0, 8'h00, 8'h00, 0, 0);
    add("garbage",  7, 64'hA5_A5_00_00_00_00_00_00 & 64'h0 | 64'h00FFA540_01A51A00,
        1, 8'h40, 1, 8'hA5, 8'h00, 0, 0);

    // reset state
    #12;
    chk("rst_valid", 32'(bus.o_cmd_valid), 32'd0);
    chk("rst_ack",   32'(bus.o_rx_ack), 32'd0);
    chk("rst_op",    32'(bus.o_cmd_op), 32'd0);
    chk("rst_len",   32'(bus.o_cmd_len), 32'd0);
    chk("rst_errs",  32'({bus.o_err_csum, bus.o_err_len, bus.o_err_timeout}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[k]) begin
      for (int i = 0; i < vecs[k].n; i++) send_byte(vecs[k].b[i]);
      chk({vecs[k].name, "_valid"}, 32'(bus.o_cmd_valid), 32'(vecs[k].exp_valid));
      chk({vecs[k].name, "_ecsum"}, 32'(bus.o_err_csum), 32'(vecs[k].exp_ecsum));
      chk({vecs[k].name, "_elen"},  32'(bus.o_err_len),  32'(vecs[k].exp_elen));
      chk({vecs[k].name, "_etmo"},  32'(bus.o_err_timeout), 32'd0);
      if (vecs[k].exp_valid) begin
        chk({vecs[k].name, "_op"},  32'(bus.o_cmd_op),  32'(vecs[k].exp_op));
        chk({vecs[k].name, "_len"}, 32'(bus.o_cmd_len), 32'(vecs[k].exp_len));
        if (vecs[k].exp_len >= 1) begin
          bus.i_pl_addr = 4'd0;
          #1 chk({vecs[k].name, "_pl0"}, 32'(bus.o_pl_data), 32'(vecs[k].exp_pl0));
        end
        if (vecs[k].exp_len >= 2) begin
          bus.i_pl_addr = 4'd1;
          #1 chk({vecs[k].name, "_pl1"}, 32'(bus.o_pl_data), 32'(vecs[k].exp_pl1));
        end
        drain(vecs[k].name);
      end else begin
        @(negedge clk);
        #1 chk({vecs[k].name, "_pulse_once"},
               32'({bus.o_err_csum, bus.o_err_len, bus.o_err_timeout}), 32'd0);
      end
    end

    // Backpressure: next SYNC held by the receiver while the command waits.
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'hBB);
    chk("bp_valid", 32'(bus.o_cmd_valid), 32'd1);
    bus.i_rx_data = 8'hA5; bus.i_rx_rdy = 1'b1;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      #1 if (bus.o_rx_ack !== 1'b0 || bus.o_cmd_valid !== 1'b1) bad++;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    bus.i_cmd_ready = 1'b1;
    @(negedge clk);
    bus.i_cmd_ready = 1'b0;
    #1;
    chk("bp_valid_drop", 32'(bus.o_cmd_valid), 32'd0);
    chk("bp_ack_after",  32'(bus.o_rx_ack), 32'd1);
    @(negedge clk);
    bus.i_rx_rdy = 1'b0;
    send_byte(8'h10); send_byte(8'h00); send_byte(8'hF0);
    chk("bp_next_valid", 32'(bus.o_cmd_valid), 32'd1);
    chk("bp_next_op",    32'(bus.o_cmd_op), 32'h10);
    drain("bp_next");

    // Maximum length boundary (LEN == MAX_LEN).
    send_byte(8'hA5); send_byte(8'h50); send_byte(8'h10);
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'h28);
    chk("max_valid", 32'(bus.o_cmd_valid), 32'd1);
    chk("max_len",   32'(bus.o_cmd_len), 32'd16);
    bus.i_pl_addr = 4'd15;
    #1 chk("max_pl15", 32'(bus.o_pl_data), 32'h0F);
    bus.i_pl_addr = 4'd7;
    #1 chk("max_pl7",  32'(bus.o_pl_data), 32'h07);
    drain("max");

    // Timeout after OP byte.
    send_byte(8'hA5); send_byte(8'h10);
    first = -1; cnt = 0;
    for (int k = 1; k <= TMO + 5; k++) begin
      @(negedge clk);
      #1 if (bus.o_err_timeout === 1'b1) begin
        cnt++;
        if (first < 0) first = k;
      end
    end
    chk("tmo_count", 32'(cnt), 32'd1);
    chk("tmo_when",  32'(first), 32'(TMO));
    send_byte(8'h33);
    chk("tmo_33_valid", 32'(bus.o_cmd_valid), 32'd0);
    chk("tmo_33_errs",  32'({bus.o_err_csum, bus.o_err_len, bus.o_err_timeout}), 32'd0);
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00); send_byte(8'hD0);
    chk("tmo_recover", 32'(bus.o_cmd_valid), 32'd1);
    drain("tmo_recover");

    // Async reset mid-PAYLOAD with a byte on offer.
    send_byte(8'hA5); send_byte(8'h10); send_byte(8'h02); send_byte(8'h11);
    bus.i_rx_data = 8'h22; bus.i_rx_rdy = 1'b1;
    #1 chk("rstp_ack_pre", 32'(bus.o_rx_ack), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstp_ack",   32'(bus.o_rx_ack), 32'd0);
    chk("rstp_valid", 32'(bus.o_cmd_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("rstp_held_byte_ack", 32'(bus.o_rx_ack), 32'd1);
    @(negedge clk);
    bus.i_rx_rdy = 1'b0;
    send_byte(8'hA5); send_byte(8'h30); send_byte(8'h00); send_byte(8'hD0);
    chk("rstp_recover", 32'(bus.o_cmd_valid), 32'd1);

    // Async reset while a command is issued.
    rst_n = 1'b0;
    #1;
    chk("rsti_valid", 32'(bus.o_cmd_valid), 32'd0);
    chk("rsti_op",    32'(bus.o_cmd_op), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
- Sequencer that drains the UART receiver's byte stream over its ready/ack handshake.
- Assembles framed debug commands (SYNC, OP, LEN, PAYLOAD[LEN], CSUM) and presents each validated command to the debug core over a valid/ready interface.
- Sits between the UART receiver and the nX-U8 debug/programming engine.
- Applies backpressure by withholding ack and discards malformed or stalled frames.

Parameters:
- MAX_LEN, 16: maximum payload bytes per frame; sets payload buffer depth.
- TIMEOUT_CYCLES, 21700: inter-byte timeout in i_clk cycles (~10 byte times at 217 cycles/bit).
- SYNC_BYTE, 8'hA5: frame start marker.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_rx_data  in  8  received byte from the UART receiver.
- i_rx_rdy  in  1  byte available; held by the receiver until acked.
- o_rx_ack  out  1  byte consumed this cycle (combinational).
- o_cmd_valid  out  1  command frame complete and verified.
- i_cmd_ready  in  1  debug core accepts the command.
- o_cmd_op  out  8  command opcode.
- o_cmd_len  out  $clog2(MAX_LEN+1)  payload length.
- i_pl_addr  in  $clog2(MAX_LEN)  payload read address.
- o_pl_data  out  8  payload byte at i_pl_addr (combinational read).
- o_err_csum  out  1  one-cycle pulse: checksum mismatch.
- o_err_len  out  1  one-cycle pulse: LEN > MAX_LEN.
- o_err_timeout  out  1  one-cycle pulse: inter-byte timeout.

Behaviour:
- Reset (async, i_rst_n=0):
  - state=HUNT.
  - o_cmd_valid, all error pulses, op, len, checksum accumulator, byte index and timeout counter = 0.
  - o_rx_ack=0 while reset is asserted.
  - Payload buffer contents are not reset.
  - Reset mid-frame abandons the frame; the byte currently held by the receiver is handled normally after reset releases.
- Consume event: i_rx_rdy && o_rx_ack.
  - o_rx_ack = i_rx_rdy in states HUNT/OP/LEN/PAYLOAD/CSUM; 0 in ISSUE.
  - The receiver drops rdy the cycle after ack, so at most one consume per byte.
- States:
  - HUNT: consumes every byte. Byte==SYNC_BYTE -> OP; anything else is discarded and state stays HUNT.
  - OP: consume -> latch op, csum_acc=byte -> LEN.
  - LEN: on consume:
    - byte > MAX_LEN -> pulse o_err_len, -> HUNT.
    - byte == 0 -> CSUM.
    - otherwise -> PAYLOAD.
    - In both non-error cases latch len, csum_acc += byte, idx=0.
  - PAYLOAD: consume -> buf[idx]=byte, csum_acc += byte, idx++. -> CSUM when idx==len-1 on that consume.
  - CSUM: consume -> check (csum_acc + byte) mod 256 == 0.
    - Pass: -> ISSUE.
    - Fail: pulse o_err_csum (cycle after consume), -> HUNT.
  - ISSUE: o_cmd_valid=1 with op/len/payload stable. Leave to HUNT on the cycle i_cmd_ready=1 (o_cmd_valid deasserts next cycle). o_rx_ack=0 throughout, so the receiver holds the next byte.
- Latency: o_cmd_valid rises the cycle after the CSUM byte is consumed. Error pulses also appear the cycle after the offending consume.
- Checksum arithmetic: 8-bit wrap-around sum over OP, LEN, payload and CSUM bytes; SYNC_BYTE excluded.
- Timeout:
  - Counter cleared on every consume and in HUNT/ISSUE; counts in OP/LEN/PAYLOAD/CSUM.
  - Reaching TIMEOUT_CYCLES-1 -> pulse o_err_timeout, -> HUNT.
  - If a consume occurs on the same cycle the counter hits TIMEOUT_CYCLES-1, the consume wins and there is no timeout.
- SYNC_BYTE inside OP/LEN/PAYLOAD/CSUM is ordinary data, not a resync.
- o_pl_data is valid for addresses < len while o_cmd_valid=1; otherwise undefined.
- i_cmd_ready outside ISSUE is ignored.

Decomposition:
- Shared debug package/header holds:
  - FSM state encoding (HUNT, OP, LEN, PAYLOAD, CSUM, ISSUE; 3 bits).
  - SYNC_BYTE default.
  - Opcode constants used by the debug core.
  - Error-code constants.
- One sub-module: cmd_payload_buf. MAX_LEN x 8 register file with one synchronous write port and one combinational read port.

Test Plan:
- Good frame: A5 10 02 11 22 BB, i_cmd_ready=1 -> o_cmd_valid one cycle after BB consumed; op=10, len=2, buf[0]=11, buf[1]=22; no error pulses.
- Backpressure: same frame followed immediately by A5, i_cmd_ready held 0 for 50 cycles -> o_rx_ack stays 0 and o_cmd_valid stays 1 throughout; the next A5 is consumed only after ready=1.
- Bad checksum: A5 10 02 11 22 BC -> o_err_csum pulses once, no o_cmd_valid; the following good frame completes normally.
- Oversize / zero length:
  - A5 20 11 with MAX_LEN=16 -> o_err_len pulses, state HUNT.
  - A5 30 00 D0 -> o_cmd_valid with len=0.
- Timeout: A5 10, then no byte for TIMEOUT_CYCLES -> o_err_timeout pulses exactly once; the next byte 33 is discarded in HUNT.
- Garbage and async reset:
  - 00 FF A5 ... good frame -> leading bytes discarded, frame issued.
  - Assert i_rst_n=0 mid-PAYLOAD -> o_cmd_valid=0 and o_rx_ack=0 immediately (asynchronous reset); after release, state is HUNT.
